// File: rtl/mem_stage_access_ctrl.sv
// MEM-stage data-memory access controller: turns the EX/MEM load/store fields into a
// req/ack bus transaction with byte strobes, stalls the pipe, and returns extended load data.
module mem_stage_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        inMemRead,
  input  logic        inMemWrite,
  input  logic [1:0]  inSIZE,
  input  logic        inlwusig,
  input  logic [31:0] inALUans,
  input  logic [31:0] inforb,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [3:0]  DMEM_BE,
  output logic [31:0] DMEM_WDATA,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic        MEM_STALL,
  output logic [31:0] LOAD_DATA,
  output logic        LOAD_VALID,
  output logic        MEM_ERR,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
  logic [3:0]  be_q, be_d;
  logic [1:0]  size_q, size_d, alo_q, alo_d;
  logic        lwu_q, lwu_d, lv_q, lv_d, err_q, err_d;
  logic        access, illegal, timeout, stall;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, rd_ext;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign access  = inMemRead | inMemWrite;
  assign illegal = (inMemRead & inMemWrite) | (inSIZE == 2'b11)
                 | ((inSIZE == SZ_HALF) & inALUans[0])
                 | ((inSIZE == SZ_WORD) & (inALUans[1:0] != 2'b00));
  assign timeout = (cnt_q == CNT_LAST);

  // Store lane placement from the incoming instruction.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = inforb;
    case (inSIZE)
      SZ_HALF: begin
        be_new    = inALUans[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{inforb[15:0]}};
      end
      SZ_BYTE: begin
        be_new    = 4'b0001 << inALUans[1:0];
        wdata_new = {4{inforb[7:0]}};
      end
      default: ;
    endcase
  end

  // Load extraction uses the lane and size latched at issue.
  always_comb begin
    half_sel = alo_q[1] ? DMEM_RDATA[31:16] : DMEM_RDATA[15:0];
    case (alo_q)
      2'd0:    byte_sel = DMEM_RDATA[7:0];
      2'd1:    byte_sel = DMEM_RDATA[15:8];
      2'd2:    byte_sel = DMEM_RDATA[23:16];
      default: byte_sel = DMEM_RDATA[31:24];
    endcase
    case (size_q)
      SZ_HALF: rd_ext = {{16{~lwu_q & half_sel[15]}}, half_sel};
      SZ_BYTE: rd_ext = {{24{~lwu_q & byte_sel[7]}}, byte_sel};
      default: rd_ext = DMEM_RDATA;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (access) state_d = illegal ? DONE : ACCESS;
      ACCESS:  if (DMEM_ACK || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall   = 1'b0;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    lwu_d   = lwu_q;
    alo_d   = alo_q;
    ld_d    = ld_q;
    lv_d    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (access) begin
        stall = 1'b1;
        if (illegal) begin
          err_d = 1'b1;
        end else begin
          req_d   = 1'b1;
          we_d    = inMemWrite;
          addr_d  = {inALUans[31:2], 2'b00};
          be_d    = be_new;
          wdata_d = wdata_new;
          size_d  = inSIZE;
          lwu_d   = inlwusig;
          alo_d   = inALUans[1:0];
          cnt_d   = 16'd0;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (DMEM_ACK) begin
          req_d = 1'b0;
          if (!we_q) begin
            ld_d = rd_ext;
            lv_d = 1'b1;
          end
        end else if (timeout) begin
          req_d = 1'b0;
          ld_d  = 32'd0;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      cnt_q   <= 16'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      size_q  <= 2'd0;
      lwu_q   <= 1'b0;
      alo_q   <= 2'd0;
      ld_q    <= 32'd0;
      lv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      lwu_q   <= lwu_d;
      alo_q   <= alo_d;
      ld_q    <= ld_d;
      lv_q    <= lv_d;
      err_q   <= err_d;
    end
  end

  // Stall is gated by reset so an in-flight instruction cannot hold the pipe during reset.
  assign MEM_STALL   = stall & RESET;
  assign DMEM_REQ    = req_q;
  assign DMEM_WE     = we_q;
  assign DMEM_ADDR   = addr_q;
  assign DMEM_BE     = be_q;
  assign DMEM_WDATA  = wdata_q;
  assign LOAD_DATA   = ld_q;
  assign LOAD_VALID  = lv_q;
  assign MEM_ERR     = err_q;
  assign dbg_state_o = state_q;

endmodule
